// File: rtl/inv_aes_pkg.sv
// Shared definitions for the AES decryption state memory: opcodes, FSM states,
// inverse S-box table and GF(2^8) multiply helpers.
package inv_aes_pkg;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_ISR = 2'b10;
    localparam logic [1:0] OP_IMC = 2'b11;

    typedef enum logic {IDLE, MIX} mix_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Source address for InvShiftRows: row r of column c comes from column (c - r) mod 4.
    function automatic logic [3:0] isr_src(input logic [3:0] a);
        return {a[3:2] - a[1:0], a[1:0]};
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] s;
        s = 8'h00;
        case (b)
            8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5;
            8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
            8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e;
            8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
            8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82;
            8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
            8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44;
            8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
            8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32;
            8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
            8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b;
            8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
            8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66;
            8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
            8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49;
            8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
            8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64;
            8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
            8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc;
            8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
            8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50;
            8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
            8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57;
            8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
            8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00;
            8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
            8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05;
            8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
            8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f;
            8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
            8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03;
            8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
            8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41;
            8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
            8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce;
            8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
            8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22;
            8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
            8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8;
            8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
            8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71;
            8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
            8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e;
            8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
            8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b;
            8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
            8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe;
            8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
            8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33;
            8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
            8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59;
            8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
            8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9;
            8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
            8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f;
            8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
            8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d;
            8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
            8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c;
            8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
            8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e;
            8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
            8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63;
            8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/inv_data_mem_if.sv
// Byte-wide host bus of the decryption state memory.
// KeyXor exists only when INV_MEM_ADDKEY_EN is defined.
interface inv_data_mem_if;
    logic [7:0] DataIN;
    logic [3:0] Add;
    logic       CS;
    logic [1:0] RWSM;
    logic [7:0] DataOUT;
    logic       BUSY;
    logic       DONE;
`ifdef INV_MEM_ADDKEY_EN
    logic       KeyXor;

    modport master (output DataIN, Add, CS, RWSM, KeyXor, input DataOUT, BUSY, DONE);
    modport slave  (input DataIN, Add, CS, RWSM, KeyXor, output DataOUT, BUSY, DONE);
`else
    modport master (output DataIN, Add, CS, RWSM, input DataOUT, BUSY, DONE);
    modport slave  (input DataIN, Add, CS, RWSM, output DataOUT, BUSY, DONE);
`endif
endinterface

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns of one 32-bit column; byte r of the column sits at [8*r +: 8].
module inv_mix_column
    import inv_aes_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);
    logic [7:0] a0, a1, a2, a3;

    assign {a3, a2, a1, a0} = col_i;

    assign col_o[7:0]   = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
    assign col_o[15:8]  = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
    assign col_o[23:16] = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
    assign col_o[31:24] = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);
endmodule

// File: rtl/inv_data_mem.sv
// 16-byte AES decryption state memory with in-place InvShiftRows+InvSubBytes and multi-cycle
// InvMixColumns. Define INV_MEM_ADDKEY_EN to enable XOR-writes (byte-serial AddRoundKey).
module inv_data_mem
    import inv_aes_pkg::*;
#(
    parameter int unsigned MIX_COLS_PER_CYC = 1
) (
    input  logic           CLK,
    input  logic           RST,
    inv_data_mem_if.slave  bus
);
    localparam logic [1:0] Step    = 2'(MIX_COLS_PER_CYC);
    localparam logic [1:0] LastGrp = 2'(4 - MIX_COLS_PER_CYC);

    logic [7:0]  mem_q [16];
    logic [7:0]  mem_d [16];
    logic [7:0]  dout_q, dout_d;
    mix_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        last_grp;

    logic [1:0]  col_idx [MIX_COLS_PER_CYC];
    logic [31:0] col_in  [MIX_COLS_PER_CYC];
    logic [31:0] col_out [MIX_COLS_PER_CYC];

    for (genvar g = 0; g < MIX_COLS_PER_CYC; g++) begin : g_mix
        assign col_idx[g] = cnt_q + 2'(g);
        assign col_in[g]  = {mem_q[{col_idx[g], 2'd3}], mem_q[{col_idx[g], 2'd2}],
                             mem_q[{col_idx[g], 2'd1}], mem_q[{col_idx[g], 2'd0}]};
        inv_mix_column u_mix (
            .col_i(col_in[g]),
            .col_o(col_out[g])
        );
    end

    assign last_grp = (cnt_q == LastGrp);

    always_comb begin
        mem_d   = mem_q;
        dout_d  = dout_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == MIX) begin
            // Host commands are ignored for the whole mix; the counter wraps back to 0.
            for (int g = 0; g < int'(MIX_COLS_PER_CYC); g++) begin
                for (int r = 0; r < 4; r++) begin
                    mem_d[{col_idx[g], 2'(r)}] = col_out[g][8*r +: 8];
                end
            end
            cnt_d = cnt_q + Step;
            if (last_grp) state_d = IDLE;
        end else if (bus.CS) begin
            case (bus.RWSM)
                OP_RD: dout_d = mem_q[bus.Add];
`ifdef INV_MEM_ADDKEY_EN
                OP_WR: mem_d[bus.Add] = bus.KeyXor ? (mem_q[bus.Add] ^ bus.DataIN) : bus.DataIN;
`else
                OP_WR: mem_d[bus.Add] = bus.DataIN;
`endif
                OP_ISR: begin
                    for (int a = 0; a < 16; a++) begin
                        mem_d[4'(a)] = inv_sbox(mem_q[isr_src(4'(a))]);
                    end
                end
                OP_IMC: begin
                    state_d = MIX;
                    cnt_d   = 2'd0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int a = 0; a < 16; a++) mem_q[a] <= 8'h00;
            dout_q  <= 8'h00;
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            mem_q   <= mem_d;
            dout_q  <= dout_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.DataOUT = dout_q;
    assign bus.BUSY    = (state_q == MIX);
    assign bus.DONE    = (state_q == MIX) && last_grp;
endmodule

// File: tb/tb_inv_data_mem.sv
// Self-checking bench for inv_data_mem: directed steps plus random traffic against a byte-array
// model whose inverse S-box is derived from GF(2^8) inversion and the AES affine map.
module tb_inv_data_mem;
    localparam int unsigned K = 1;
    localparam logic [1:0] RD = 2'b00, WR = 2'b01, ISR = 2'b10, IMC = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [7:0] m [16];
    logic [7:0] dout_m;
    logic [7:0] inv_tab [256];
    logic [7:0] coef [4];
    logic [7:0] imc_vec [4];

    inv_data_mem_if bus ();

    inv_data_mem #(.MIX_COLS_PER_CYC(K)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d,
                         input logic kx);
        @(negedge clk);
        bus.RWSM   = op;
        bus.Add    = a;
        bus.DataIN = d;
        bus.CS     = 1'b1;
`ifdef INV_MEM_ADDKEY_EN
        bus.KeyXor = kx;
`else
        if (kx) bus.DataIN = d;
`endif
    endtask

    task automatic cmd(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d,
                       input logic kx);
        drive(op, a, d, kx);
        @(posedge clk);
        #1;
        bus.CS = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic kx);
        cmd(WR, a, d, kx);
`ifdef INV_MEM_ADDKEY_EN
        m[a] = kx ? (m[a] ^ d) : d;
`else
        m[a] = d;
`endif
        check("wr_hold_dout", bus.DataOUT, dout_m);
    endtask

    task automatic rd(input logic [3:0] a, input string tag);
        cmd(RD, a, 8'h00, 1'b0);
        dout_m = m[a];
        check(tag, bus.DataOUT, m[a]);
    endtask

    task automatic rd_all(input string tag);
        for (int a = 0; a < 16; a++) rd(4'(a), tag);
    endtask

    task automatic isr_op();
        logic [7:0] t [16];
        cmd(ISR, 4'h0, 8'h00, 1'b0);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c + r] = inv_tab[m[4*((c - r + 4) % 4) + r]];
        m = t;
    endtask

    // Runs one IMC, optionally firing a WRITE and a second IMC while busy.
    task automatic imc_op(input bit inject, input string tag);
        int busy_n, done_n;
        logic done_last;
        logic [7:0] t [16];
        busy_n = 0; done_n = 0; done_last = 1'b0;
        cmd(IMC, 4'h0, 8'h00, 1'b0);
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (!bus.BUSY) break;
            busy_n++;
            if (bus.DONE) done_n++;
            done_last = bus.DONE;
            if (inject && cyc < 2) begin
                if (cyc == 0) drive(WR, 4'h0, 8'hff, 1'b0);
                else          drive(IMC, 4'h0, 8'h00, 1'b0);
            end
            @(posedge clk);
            #1;
            bus.CS = 1'b0;
        end
        check({tag, "_busy_cycles"}, 8'(busy_n), 8'(4 / K));
        check({tag, "_done_count"}, 8'(done_n), 8'd1);
        check({tag, "_done_on_last"}, {7'd0, done_last}, 8'd1);
        check({tag, "_done_low_after"}, {7'd0, bus.DONE}, 8'd0);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                t[4*c + r] = 8'h00;
                for (int j = 0; j < 4; j++)
                    t[4*c + r] = t[4*c + r] ^ gf_mul(coef[(j - r + 4) % 4], m[4*c + j]);
            end
        m = t;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check({tag, "_busy"}, {7'd0, bus.BUSY}, 8'd0);
        check({tag, "_done"}, {7'd0, bus.DONE}, 8'd0);
        check({tag, "_dout"}, bus.DataOUT, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 16; a++) m[a] = 8'h00;
        dout_m = 8'h00;
    endtask

    initial begin
        logic [7:0] sb, inv;
        logic seen_done;
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        imc_vec = '{8'hdb, 8'h13, 8'h53, 8'h45};
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            inv_tab[sb] = 8'(x);
        end
        for (int a = 0; a < 16; a++) m[a] = 8'h00;
        dout_m = 8'h00;
        bus.CS = 1'b0; bus.RWSM = RD; bus.Add = 4'h0; bus.DataIN = 8'h00;
`ifdef INV_MEM_ADDKEY_EN
        bus.KeyXor = 1'b0;
`endif

        // Power-on reset, then reset mid-run.
        repeat (2) @(posedge clk);
        #1;
        check("por_dout", bus.DataOUT, 8'h00);
        check("por_busy", {7'd0, bus.BUSY}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 16; a++) wr(4'(a), 8'($urandom), 1'b0);
        rd(4'h7, "t1_pre_read");
        do_reset("t1_reset");
        rd_all("t1_read_zero");

        // Write/read pattern.
        for (int a = 0; a < 16; a++) wr(4'(a), 8'(a * 8'h11), 1'b0);
        rd_all("t2_read");

        // ISR on the directed pattern.
        for (int a = 0; a < 16; a++) wr(4'(a), 8'h63, 1'b0);
        wr(4'h5, 8'hed, 1'b0);
        wr(4'h1, 8'h00, 1'b0);
        isr_op();
        rd(4'h5, "t3_addr5");
        check("t3_addr5_const", bus.DataOUT, 8'h52);
        rd(4'h9, "t3_addr9");
        check("t3_addr9_const", bus.DataOUT, 8'h53);
        rd_all("t3_read");

        // IMC on the reference column.
        for (int c = 0; c < 4; c++) begin
            wr(4'(4*c), 8'h8e, 1'b0); wr(4'(4*c + 1), 8'h4d, 1'b0);
            wr(4'(4*c + 2), 8'ha1, 1'b0); wr(4'(4*c + 3), 8'hbc, 1'b0);
        end
        imc_op(1'b0, "t4");
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), "t4_read");
            check("t4_const", bus.DataOUT, imc_vec[a % 4]);
        end

        // Collisions while busy: WRITE and IMC both dropped.
        for (int c = 0; c < 4; c++) begin
            wr(4'(4*c), 8'h8e, 1'b0); wr(4'(4*c + 1), 8'h4d, 1'b0);
            wr(4'(4*c + 2), 8'ha1, 1'b0); wr(4'(4*c + 3), 8'hbc, 1'b0);
        end
        imc_op(1'b1, "t5");
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), "t5_read");
            check("t5_const", bus.DataOUT, imc_vec[a % 4]);
        end

        // Reset in the middle of an IMC: no DONE, memory cleared.
        for (int a = 0; a < 16; a++) wr(4'(a), 8'($urandom), 1'b0);
        cmd(IMC, 4'h0, 8'h00, 1'b0);
        seen_done = bus.DONE;
        @(negedge clk);
        rst = 1'b1;
        #1;
        seen_done = seen_done | bus.DONE;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            seen_done = seen_done | bus.DONE;
        end
        check("t5_rst_no_done", {7'd0, seen_done}, 8'd0);
        check("t5_rst_busy", {7'd0, bus.BUSY}, 8'd0);
        for (int a = 0; a < 16; a++) m[a] = 8'h00;
        dout_m = 8'h00;
        rd_all("t5_rst_read");

`ifdef INV_MEM_ADDKEY_EN
        wr(4'h3, 8'ha5, 1'b0);
        wr(4'h3, 8'h0f, 1'b1);
        rd(4'h3, "t6_xor");
        check("t6_xor_const", bus.DataOUT, 8'haa);
        wr(4'h3, 8'h0f, 1'b0);
        rd(4'h3, "t6_overwrite");
        check("t6_overwrite_const", bus.DataOUT, 8'h0f);
`endif

        // Random traffic against the model.
        for (int a = 0; a < 16; a++) wr(4'(a), 8'($urandom), 1'b0);
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0, 1: wr(4'($urandom), 8'($urandom), 1'($urandom));
                2, 3: rd(4'($urandom), "rnd_read");
                4:    isr_op();
                default: imc_op(1'($urandom), "rnd_imc");
            endcase
        end
        rd_all("rnd_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
